// File: rtl/us_cmd_arbiter_pkg.sv
// ============================================================================
//  Module   : us_cmd_arbiter_pkg
//  Purpose  : Shared command-word layout, type codes and arbiter state type.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package us_cmd_arbiter_pkg;

   localparam logic [1:0] US_CMD_WR32_TYPE = 2'b01;
   localparam logic [1:0] US_CMD_CPLD_TYPE = 2'b10;

   localparam int WORD_W     = 128;
   localparam int CPL_DESC_W = 55;
   localparam int TYPE_LSB   = 62;
   localparam int LEN_LSB    = 57;
   localparam int ID_LSB     = 55;
   localparam int ADDR_LSB   = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_t;

   // Returns {found, index} of the lowest set bit in free_mask.
   function automatic logic [2:0] lowest_free(input logic [3:0] free_mask);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (free_mask[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/us_cmd_slot_alloc.sv
// ============================================================================
//  Module   : us_cmd_slot_alloc
//  Purpose  : cmd_id busy bitmap, lowest-free encoder and completion checking.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module us_cmd_slot_alloc
   import us_cmd_arbiter_pkg::*;
#(
   parameter int NUM_SLOTS = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       alloc_en,
   input  logic [1:0] alloc_id,
   input  logic       free_en,
   input  logic [1:0] free_id,
   output logic [3:0] slot_busy,
   output logic       free_avail,
   output logic [1:0] free_id_low,
   output logic       compl_err
);

   localparam logic [3:0] SLOT_MASK = 4'((1 << NUM_SLOTS) - 1);

   logic [3:0] r_busy;
   logic       r_err;
   logic [3:0] w_alloc_mask;
   logic [3:0] w_free_mask;
   logic       w_free_ok;
   logic [2:0] w_low;

   always_comb begin
      w_free_ok    = free_en && SLOT_MASK[free_id] && r_busy[free_id];
      w_alloc_mask = alloc_en ? ((4'b0001 << alloc_id) & SLOT_MASK) : 4'b0000;
      w_free_mask  = w_free_ok ? (4'b0001 << free_id) : 4'b0000;
      // Only the registered bitmap is searched, so a slot freed this cycle waits a cycle.
      w_low        = lowest_free(~r_busy & SLOT_MASK);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 4'b0000;
         r_err  <= 1'b0;
      end else begin
         r_busy <= (r_busy | w_alloc_mask) & ~w_free_mask;
         r_err  <= free_en && !w_free_ok;
      end
   end

   assign slot_busy   = r_busy;
   assign free_avail  = w_low[2];
   assign free_id_low = w_low[1:0];
   assign compl_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/us_cmd_arbiter.sv
// ============================================================================
//  Module   : us_cmd_arbiter
//  Purpose  : Round-robin CPLD / WR32 arbiter and sole writer of us_cmd_fifo.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module us_cmd_arbiter
   import us_cmd_arbiter_pkg::*;
#(
   parameter int NUM_SLOTS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpl_req_i,
   input  logic [CPL_DESC_W-1:0] cpl_desc_i,
   output logic                  cpl_ack_o,
   input  logic                  wr_req_i,
   input  logic [4:0]            wr_len_i,
   input  logic [31:0]           wr_addr_i,
   output logic                  wr_ack_o,
   output logic [1:0]            wr_id_o,
   input  logic                  up_wr_cmd_compl_i,
   input  logic [1:0]            cmd_id_i,
   input  logic                  us_cmd_fifo_full_i,
   input  logic                  us_cmd_fifo_prog_full_i,
   output logic [WORD_W-1:0]     us_cmd_fifo_din_o,
   output logic                  us_cmd_fifo_wr_en_o,
   output logic [3:0]            slot_busy_o,
   output logic                  compl_err_o
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_grant_cpl;
   logic              w_grant_cpl_nxt;
   logic              r_rr_cpl;
   logic              w_rr_cpl_nxt;
   logic [1:0]        r_wr_id;
   logic [1:0]        w_wr_id_nxt;
   logic              w_elig_cpl;
   logic              w_elig_wr;
   logic              w_issue;
   logic              w_cpl_ack;
   logic              w_wr_ack;
   logic [WORD_W-1:0] w_din;
   logic              w_free_avail;
   logic [1:0]        w_free_id_low;

   us_cmd_slot_alloc #(
      .NUM_SLOTS (NUM_SLOTS)
   ) u_slot_alloc (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc_en    (w_wr_ack),
      .alloc_id    (r_wr_id),
      .free_en     (up_wr_cmd_compl_i),
      .free_id     (cmd_id_i),
      .slot_busy   (slot_busy_o),
      .free_avail  (w_free_avail),
      .free_id_low (w_free_id_low),
      .compl_err   (compl_err_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_grant_cpl <= 1'b0;
         r_rr_cpl    <= 1'b1;
         r_wr_id     <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant_cpl <= w_grant_cpl_nxt;
         r_rr_cpl    <= w_rr_cpl_nxt;
         r_wr_id     <= w_wr_id_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_grant_cpl_nxt = r_grant_cpl;
      w_rr_cpl_nxt    = r_rr_cpl;
      w_wr_id_nxt     = r_wr_id;
      w_issue         = 1'b0;
      // Completions ignore prog_full so the non-posted read path keeps draining.
      w_elig_cpl      = cpl_req_i && !us_cmd_fifo_full_i;
      w_elig_wr       = wr_req_i && !us_cmd_fifo_prog_full_i && !us_cmd_fifo_full_i
                        && w_free_avail;

      case (r_state)
         ST_IDLE: begin
            if (w_elig_cpl || w_elig_wr) begin
               w_grant_cpl_nxt = w_elig_cpl && (!w_elig_wr || r_rr_cpl);
               w_wr_id_nxt     = w_free_id_low;
               w_state_nxt     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_issue      = 1'b1;
            w_rr_cpl_nxt = !r_grant_cpl;
            w_state_nxt  = ST_GAP;
         end
         ST_GAP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_cpl_ack = w_issue && r_grant_cpl;
      w_wr_ack  = w_issue && !r_grant_cpl;

      w_din = '0;
      if (w_cpl_ack) begin
         w_din[TYPE_LSB +: 2]         = US_CMD_CPLD_TYPE;
         w_din[CPL_DESC_W-1:0]        = cpl_desc_i;
      end else if (w_wr_ack) begin
         w_din[TYPE_LSB +: 2]         = US_CMD_WR32_TYPE;
         w_din[LEN_LSB +: 5]          = wr_len_i;
         w_din[ID_LSB +: 2]           = r_wr_id;
         w_din[ADDR_LSB +: 32]        = wr_addr_i;
      end
   end

   assign us_cmd_fifo_wr_en_o = w_issue;
   assign us_cmd_fifo_din_o   = w_din;
   assign cpl_ack_o           = w_cpl_ack;
   assign wr_ack_o            = w_wr_ack;
   assign wr_id_o             = w_wr_ack ? r_wr_id : 2'd0;

endmodule

`default_nettype wire

// File: tb/tb_us_cmd_arbiter.sv
// ============================================================================
//  Module   : tb_us_cmd_arbiter
//  Purpose  : Self-checking bench for us_cmd_arbiter (table vectors + scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_us_cmd_arbiter;

   localparam logic [1:0] TB_CPLD = 2'b10;
   localparam logic [1:0] TB_WR32 = 2'b01;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpl_req_i;
   logic [54:0]   cpl_desc_i;
   logic          cpl_ack_o;
   logic          wr_req_i;
   logic [4:0]    wr_len_i;
   logic [31:0]   wr_addr_i;
   logic          wr_ack_o;
   logic [1:0]    wr_id_o;
   logic          up_wr_cmd_compl_i;
   logic [1:0]    cmd_id_i;
   logic          us_cmd_fifo_full_i;
   logic          us_cmd_fifo_prog_full_i;
   logic [127:0]  us_cmd_fifo_din_o;
   logic          us_cmd_fifo_wr_en_o;
   logic [3:0]    slot_busy_o;
   logic          compl_err_o;

   us_cmd_arbiter #(.NUM_SLOTS(2)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .cpl_req_i               (cpl_req_i),
      .cpl_desc_i              (cpl_desc_i),
      .cpl_ack_o               (cpl_ack_o),
      .wr_req_i                (wr_req_i),
      .wr_len_i                (wr_len_i),
      .wr_addr_i               (wr_addr_i),
      .wr_ack_o                (wr_ack_o),
      .wr_id_o                 (wr_id_o),
      .up_wr_cmd_compl_i       (up_wr_cmd_compl_i),
      .cmd_id_i                (cmd_id_i),
      .us_cmd_fifo_full_i      (us_cmd_fifo_full_i),
      .us_cmd_fifo_prog_full_i (us_cmd_fifo_prog_full_i),
      .us_cmd_fifo_din_o       (us_cmd_fifo_din_o),
      .us_cmd_fifo_wr_en_o     (us_cmd_fifo_wr_en_o),
      .slot_busy_o             (slot_busy_o),
      .compl_err_o             (compl_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] din;
      bit           is_cpl;
      logic [1:0]   id;
   } exp_t;

   typedef struct {
      bit           is_cpl;
      logic [54:0]  desc;
      logic [4:0]   len;
      logic [31:0]  addr;
      logic [127:0] exp_din;
      logic [1:0]   exp_id;
      logic [3:0]   exp_busy;
   } vec_t;

   exp_t       exp_q[$];
   int         wr_cyc_q[$];
   exp_t       mon_e;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         n_wr    = 0;
   int         n_stray = 0;
   logic [3:0] m_busy;

   function automatic logic [54:0] mk_desc(input logic [2:0] tc, input logic td,
      input logic ep, input logic [1:0] attr, input logic [9:0] len, input logic [15:0] rid,
      input logic [7:0] tag, input logic [7:0] be, input logic [5:0] addr);
      return {tc, td, ep, attr, len, rid, tag, be, addr};
   endfunction

   function automatic logic [127:0] mk_cpl_word(input logic [54:0] d);
      logic [127:0] w;
      w        = '0;
      w[63:62] = TB_CPLD;
      w[54:0]  = d;
      return w;
   endfunction

   function automatic logic [127:0] mk_wr_word(input logic [4:0] len, input logic [1:0] id,
      input logic [31:0] addr);
      logic [127:0] w;
      w        = '0;
      w[63:62] = TB_WR32;
      w[61:57] = len;
      w[56:55] = id;
      w[31:0]  = addr;
      return w;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [127:0] din, input bit is_cpl, input logic [1:0] id);
      exp_t e;
      e.din    = din;
      e.is_cpl = is_cpl;
      e.id     = id;
      exp_q.push_back(e);
   endtask

   task automatic push_cpl(input logic [54:0] d);
      push_exp(mk_cpl_word(d), 1'b1, 2'd0);
   endtask

   task automatic push_wr(input logic [4:0] len, input logic [31:0] addr);
      logic [1:0] id;
      id = !m_busy[0] ? 2'd0 : 2'd1;
      push_exp(mk_wr_word(len, id, addr), 1'b0, id);
      m_busy[id] = 1'b1;
   endtask

   // Waits for the requested ack, optionally checks latency, then drops the request.
   task automatic wait_ack(input bit is_cpl, input int t0, input int exp_lat, input string nm);
      bit seen;
      int lat;
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (is_cpl ? cpl_ack_o : wr_ack_o) begin
            seen = 1'b1;
            lat  = cyc - t0;
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no ack expected ack within 40 cycles", nm);
      end else if (exp_lat >= 0) begin
         check({nm, "_latency"}, lat, exp_lat);
      end
      tick();
      if (is_cpl) cpl_req_i = 1'b0;
      else        wr_req_i  = 1'b0;
   endtask

   task automatic do_free(input logic [1:0] id, input bit exp_err, input string nm);
      bit err_seen;
      err_seen          = 1'b0;
      up_wr_cmd_compl_i = 1'b1;
      cmd_id_i          = id;
      tick();
      up_wr_cmd_compl_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (compl_err_o) err_seen = 1'b1;
      end
      check({nm, "_err"}, err_seen, exp_err);
      if (!exp_err) m_busy[id] = 1'b0;
      check({nm, "_busy"}, slot_busy_o, m_busy);
      tick();
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if ((cpl_ack_o || wr_ack_o) && !us_cmd_fifo_wr_en_o) n_stray++;
         if (us_cmd_fifo_wr_en_o) begin
            n_wr++;
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got din %0h expected no write", us_cmd_fifo_din_o);
            end else begin
               mon_e = exp_q.pop_front();
               check("din", us_cmd_fifo_din_o, mon_e.din);
               check("acks", {cpl_ack_o, wr_ack_o}, {mon_e.is_cpl, !mon_e.is_cpl});
               if (!mon_e.is_cpl) check("wr_id", wr_id_o, mon_e.id);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vt[6];
      int          t0;
      int          nw;
      logic [54:0] cd[3];

      rst_n                   = 1'b0;
      cpl_req_i               = 1'b0;
      cpl_desc_i              = '0;
      wr_req_i                = 1'b0;
      wr_len_i                = '0;
      wr_addr_i               = '0;
      up_wr_cmd_compl_i       = 1'b0;
      cmd_id_i                = '0;
      us_cmd_fifo_full_i      = 1'b0;
      us_cmd_fifo_prog_full_i = 1'b0;
      m_busy                  = 4'b0000;

      vt[0] = '{1'b1, mk_desc(3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h0000, 8'h05, 8'h0F, 6'h10),
                5'd0, 32'h0, '0, 2'd0, 4'b0000};
      vt[1] = '{1'b0, 55'd0, 5'd7, 32'h1000_0000, '0, 2'd0, 4'b0001};
      vt[2] = '{1'b1, mk_desc(3'd7, 1'b1, 1'b0, 2'd2, 10'h3FF, 16'hABCD, 8'hFF, 8'hF0, 6'h3F),
                5'd0, 32'h0, '0, 2'd0, 4'b0000};
      vt[3] = '{1'b0, 55'd0, 5'h1F, 32'hFFFF_FFFC, '0, 2'd0, 4'b0001};
      vt[4] = '{1'b1, {55{1'b1}}, 5'd0, 32'h0, '0, 2'd0, 4'b0000};
      vt[5] = '{1'b0, 55'd0, 5'd0, 32'h0000_0004, '0, 2'd0, 4'b0001};
      for (int i = 0; i < 6; i++) begin
         vt[i].exp_din = vt[i].is_cpl ? mk_cpl_word(vt[i].desc)
                                      : mk_wr_word(vt[i].len, vt[i].exp_id, vt[i].addr);
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_en", us_cmd_fifo_wr_en_o, 1'b0);
      check("rst_din", us_cmd_fifo_din_o, 128'd0);
      check("rst_pulses", {cpl_ack_o, wr_ack_o, compl_err_o}, 3'b000);
      check("rst_wr_id", wr_id_o, 2'd0);
      check("rst_busy", slot_busy_o, 4'b0000);
      rst_n = 1'b1;
      tick();
      tick();

      // Single-requester vectors; each write is retired so the next one gets id 0
      for (int i = 0; i < 6; i++) begin
         push_exp(vt[i].exp_din, vt[i].is_cpl, vt[i].exp_id);
         if (vt[i].is_cpl) begin
            cpl_desc_i = vt[i].desc;
            cpl_req_i  = 1'b1;
            t0 = cyc;
            wait_ack(1'b1, t0, 1, "vec_cpl");
         end else begin
            wr_len_i  = vt[i].len;
            wr_addr_i = vt[i].addr;
            wr_req_i  = 1'b1;
            t0 = cyc;
            wait_ack(1'b0, t0, 1, "vec_wr");
         end
         check("vec_busy", slot_busy_o, vt[i].exp_busy);
         m_busy = vt[i].exp_busy;
         if (!vt[i].is_cpl) do_free(vt[i].exp_id, 1'b0, "vec_free");
         tick();
      end

      // Two writes fill both slots, a third stalls until id 0 is retired
      wr_len_i  = 5'd7;
      wr_addr_i = 32'hA000_0000;
      push_wr(5'd7, 32'hA000_0000);
      wr_req_i = 1'b1;
      t0 = cyc;
      wait_ack(1'b0, t0, 1, "wr_a");
      tick();
      wr_addr_i = 32'hB000_0040;
      push_wr(5'd7, 32'hB000_0040);
      wr_req_i = 1'b1;
      t0 = cyc;
      wait_ack(1'b0, t0, 1, "wr_b");
      check("busy_two", slot_busy_o, 4'b0011);
      tick();
      wr_addr_i = 32'hC000_0080;
      push_exp(mk_wr_word(5'd7, 2'd0, 32'hC000_0080), 1'b0, 2'd0);
      wr_req_i = 1'b1;
      nw = n_wr;
      repeat (10) tick();
      check("stall_all_busy", n_wr, nw);
      up_wr_cmd_compl_i = 1'b1;
      cmd_id_i          = 2'd0;
      tick();
      up_wr_cmd_compl_i = 1'b0;
      t0 = cyc;
      wait_ack(1'b0, t0, 1, "wr_c_after_free");
      check("busy_realloc", slot_busy_o, 4'b0011);
      m_busy = 4'b0011;
      do_free(2'd0, 1'b0, "free0");
      do_free(2'd1, 1'b0, "free1");

      // Continuous contention: CPL,WR,CPL,WR,CPL, three cycles apart
      cd[0] = mk_desc(3'd1, 1'b0, 1'b1, 2'd1, 10'd4, 16'h0100, 8'h11, 8'hFF, 6'h00);
      cd[1] = mk_desc(3'd2, 1'b1, 1'b0, 2'd3, 10'd8, 16'h0200, 8'h22, 8'h0F, 6'h04);
      cd[2] = mk_desc(3'd3, 1'b0, 1'b0, 2'd0, 10'd2, 16'h0300, 8'h33, 8'hF0, 6'h08);
      push_cpl(cd[0]);
      push_wr(5'd7, 32'h0000_1000);
      push_cpl(cd[1]);
      push_wr(5'd7, 32'h0000_2000);
      push_cpl(cd[2]);
      wr_cyc_q.delete();
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               cpl_desc_i = cd[k];
               cpl_req_i  = 1'b1;
               wait_ack(1'b1, 0, -1, "cont_cpl");
            end
         end
         begin
            for (int j = 0; j < 2; j++) begin
               wr_len_i  = 5'd7;
               wr_addr_i = (j == 0) ? 32'h0000_1000 : 32'h0000_2000;
               wr_req_i  = 1'b1;
               wait_ack(1'b0, 0, -1, "cont_wr");
            end
         end
      join
      check("cont_writes", wr_cyc_q.size(), 5);
      for (int i = 1; i < wr_cyc_q.size(); i++) begin
         check("cont_spacing", wr_cyc_q[i] - wr_cyc_q[i-1], 3);
      end
      check("cont_busy", slot_busy_o, 4'b0011);
      do_free(2'd0, 1'b0, "free0b");
      do_free(2'd1, 1'b0, "free1b");

      // prog_full holds writes only
      us_cmd_fifo_prog_full_i = 1'b1;
      cd[0] = mk_desc(3'd0, 1'b0, 1'b0, 2'd0, 10'd1, 16'h1234, 8'h44, 8'h0F, 6'h20);
      push_cpl(cd[0]);
      push_wr(5'd3, 32'h0BAD_F00C);
      wr_len_i   = 5'd3;
      wr_addr_i  = 32'h0BAD_F00C;
      wr_req_i   = 1'b1;
      cpl_desc_i = cd[0];
      cpl_req_i  = 1'b1;
      t0 = cyc;
      wait_ack(1'b1, t0, 1, "pf_cpl");
      nw = n_wr;
      repeat (6) tick();
      check("pf_wr_held", n_wr, nw);
      us_cmd_fifo_prog_full_i = 1'b0;
      t0 = cyc;
      wait_ack(1'b0, t0, 1, "pf_release");
      tick();

      // full holds both; the pending CPL goes one cycle after release
      us_cmd_fifo_full_i = 1'b1;
      cd[1] = mk_desc(3'd5, 1'b1, 1'b1, 2'd1, 10'd16, 16'h5678, 8'h55, 8'hAA, 6'h2C);
      push_cpl(cd[1]);
      push_wr(5'd6, 32'h7777_0010);
      cpl_desc_i = cd[1];
      cpl_req_i  = 1'b1;
      wr_len_i   = 5'd6;
      wr_addr_i  = 32'h7777_0010;
      wr_req_i   = 1'b1;
      nw = n_wr;
      repeat (6) tick();
      check("full_both_held", n_wr, nw);
      us_cmd_fifo_full_i = 1'b0;
      t0 = cyc;
      wait_ack(1'b1, t0, 1, "full_release_cpl");
      wait_ack(1'b0, 0, -1, "full_release_wr");
      check("full_busy", slot_busy_o, 4'b0011);
      tick();

      // Completion errors
      do_free(2'd1, 1'b0, "free1c");
      do_free(2'd1, 1'b1, "idle_id1");
      do_free(2'd2, 1'b1, "oor_id2");

      // Free id 0 while id 1 is allocated in the same cycle
      wr_len_i  = 5'd2;
      wr_addr_i = 32'h0000_0ABC;
      push_wr(5'd2, 32'h0000_0ABC);
      wr_req_i = 1'b1;
      tick();
      up_wr_cmd_compl_i = 1'b1;
      cmd_id_i          = 2'd0;
      tick();
      up_wr_cmd_compl_i = 1'b0;
      wr_req_i          = 1'b0;
      m_busy[0]         = 1'b0;
      check("race_busy", slot_busy_o, 4'b0010);
      @(negedge clk);
      check("race_no_err", compl_err_o, 1'b0);
      tick();

      // Reset in ISSUE clears outputs at once, the held request is reissued with id 0
      wr_len_i  = 5'd9;
      wr_addr_i = 32'h4444_0008;
      wr_req_i  = 1'b1;
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_wr_en", us_cmd_fifo_wr_en_o, 1'b0);
      check("rst_mid_din", us_cmd_fifo_din_o, 128'd0);
      check("rst_mid_acks", {cpl_ack_o, wr_ack_o, wr_id_o}, 4'b0000);
      check("rst_mid_busy", slot_busy_o, 4'b0000);
      m_busy = 4'b0000;
      push_wr(5'd9, 32'h4444_0008);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      t0 = cyc;
      wait_ack(1'b0, t0, 1, "post_rst_wr");
      check("post_rst_busy", slot_busy_o, 4'b0001);
      tick();

      check("scoreboard_empty", exp_q.size(), 0);
      check("stray_acks", n_stray, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
